button_bounce_gen: RTL and testbench



---
 rtl/button_bounce_gen_if.sv | 23 ++
 rtl/button_bounce_gen.sv | 111 +++++++++++
 tb/tb_button_bounce_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/button_bounce_gen_if.sv
// button_bounce_gen_if
//   Press-request / bouncy-level bundle for the button emulator.
//   master : stimulus side (drives start, hold_cycles; observes the rest)
//   slave  : button_bounce_gen side
//   start        press request, sampled every clk
//   hold_cycles  stable-pressed duration, latched when start is accepted
//   btn_out      bouncy button level (1 = pressed)
//   busy         press sequence in progress
//   done         one-cycle pulse at the end of a sequence
//   toggle_cnt   bounce toggles in the current/last sequence (saturating)
interface button_bounce_gen_if #(
  parameter int HOLD_W = 24
);
  logic              start;
  logic [HOLD_W-1:0] hold_cycles;
  logic              btn_out;
  logic              busy;
  logic              done;
  logic [7:0]        toggle_cnt;

  modport master (output start, hold_cycles, input btn_out, busy, done, toggle_cnt);
  modport slave  (input start, hold_cycles, output btn_out, busy, done, toggle_cnt);
endinterface

// File: rtl/button_bounce_gen.sv
// button_bounce_gen
//   Mechanical push-button emulator. A clean press request becomes a level
//   that bounces pseudo-randomly for BOUNCE_CYCLES clocks on press, stays at
//   1 for H clocks, then bounces for BOUNCE_CYCLES clocks on release.
//   With t0 the edge that accepts start:
//     btn_out rises at t0, is solidly 1 from t0+BOUNCE_CYCLES,
//     falls at t0+BOUNCE_CYCLES+H, done pulses at t0+2*BOUNCE_CYCLES+H.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    button_bounce_gen_if.slave (start, hold_cycles in;
//            btn_out, busy, done, toggle_cnt out, all registered)
module button_bounce_gen #(
  parameter int          BOUNCE_CYCLES = 20000,
  parameter int          TOGGLE_BITS   = 8,
  parameter int          HOLD_W        = 24,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  button_bounce_gen_if.slave  bus
);

  localparam int BW = $clog2(BOUNCE_CYCLES + 1);
  localparam int GW = TOGGLE_BITS + 1;
  localparam logic [BW-1:0] BOUNCE_LD = BW'(BOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESS_BOUNCE, HELD, RELEASE_BOUNCE} state_e;

  state_e            state_q;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [GW-1:0]     gap_rand, gap_cnt_q;
  logic [BW-1:0]     bounce_cnt_q;
  logic [HOLD_W-1:0] hold_q, hold_cnt_q;
  logic              btn_q, busy_q, done_q;
  logic [7:0]        tc_q;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  // Gap is never 0, so at most one toggle per clock.
  assign gap_rand = GW'(lfsr_q[TOGGLE_BITS-1:0]) + GW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      gap_cnt_q    <= '0;
      bounce_cnt_q <= '0;
      hold_q       <= '0;
      hold_cnt_q   <= '0;
      btn_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tc_q         <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // A zero hold would never reach the hold_cnt==1 exit; use 1.
            hold_q       <= (bus.hold_cycles == '0) ? HOLD_W'(1) : bus.hold_cycles;
            btn_q        <= 1'b1;
            busy_q       <= 1'b1;
            tc_q         <= '0;
            bounce_cnt_q <= BOUNCE_LD;
            gap_cnt_q    <= gap_rand;
            state_q      <= PRESS_BOUNCE;
          end
        end
        PRESS_BOUNCE, RELEASE_BOUNCE: begin
          bounce_cnt_q <= bounce_cnt_q - BW'(1);
          gap_cnt_q    <= gap_cnt_q - GW'(1);
          if (bounce_cnt_q == BW'(1)) begin
            // Window end forces the settled level whatever the toggle parity.
            if (state_q == PRESS_BOUNCE) begin
              btn_q      <= 1'b1;
              hold_cnt_q <= hold_q;
              state_q    <= HELD;
            end else begin
              btn_q   <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (gap_cnt_q == GW'(1)) begin
            btn_q     <= ~btn_q;
            gap_cnt_q <= gap_rand;
            if (tc_q != 8'hFF) tc_q <= tc_q + 8'd1;
          end
        end
        HELD: begin
          hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
          if (hold_cnt_q == HOLD_W'(1)) begin
            btn_q        <= 1'b0;
            bounce_cnt_q <= BOUNCE_LD;
            gap_cnt_q    <= gap_rand;
            state_q      <= RELEASE_BOUNCE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.btn_out    = btn_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.toggle_cnt = tc_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// tb_button_bounce_gen
//   Table of press lengths with constant expected window timing, hand-written
//   back-to-back and async-reset sequences, then random start/hold stimulus.
//   Every cycle the DUT is compared against a schedule model: at each window
//   start the list of toggle edges is derived from the LFSR value sequence and
//   the spec's gap rule. A second instance with another seed must share the
//   window timing but not the bounce pattern.
module tb_button_bounce_gen;
  localparam int          B    = 100;
  localparam int          TB   = 4;
  localparam int          HW   = 24;
  localparam int          NMAX = 60000;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_bounce_gen_if #(.HOLD_W(HW)) bus ();
  button_bounce_gen_if #(.HOLD_W(HW)) bus2 ();
  assign bus2.start       = bus.start;
  assign bus2.hold_cycles = bus.hold_cycles;

  button_bounce_gen #(.BOUNCE_CYCLES(B), .TOGGLE_BITS(TB), .HOLD_W(HW), .LFSR_SEED(SEED))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  button_bounce_gen #(.BOUNCE_CYCLES(B), .TOGGLE_BITS(TB), .HOLD_W(HW), .LFSR_SEED(16'h1234))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int errors = 0;

  typedef struct { int hold; int exp_done; } vec_t;
  vec_t tbl[5];

  logic [15:0] lfsr_tab [NMAX];
  int          e;       // index of the next rising edge since reset release
  int          diff2;   // cycles where the second seed's level differs

  // Schedule model state
  int          m_t0, m_h, m_end;
  logic        m_btn, m_busy, m_done;
  logic [7:0]  m_tc;
  int          tq[$];

  function automatic logic [15:0] lfsr_next(logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", nm, e, act, exp);
    end
  endtask

  // Toggle edges of a bounce window opened at edge s: each gap is drawn from
  // the LFSR value present at the edge that (re)loads it.
  task automatic sched(int s);
    int t = s;
    if (s + B + 300 >= NMAX) begin
      $display("FAIL lfsr_table: edge index %0d beyond %0d", s, NMAX);
      $fatal(1);
    end
    while (1) begin
      t += int'(lfsr_tab[t][TB-1:0]) + 1;
      if (t > s + B - 1) break;
      tq.push_back(t);
    end
  endtask

  task automatic model_edge(int c, logic st, logic [HW-1:0] hc);
    m_done = 1'b0;
    if (m_busy) begin
      if (c == m_t0 + B) m_btn = 1'b1;
      if (tq.size() > 0 && tq[0] == c) begin
        void'(tq.pop_front());
        m_btn = ~m_btn;
        if (m_tc != 8'hFF) m_tc++;
      end
      if (c == m_t0 + B + m_h) begin
        m_btn = 1'b0;
        sched(c);
      end
      if (c == m_end) begin
        m_btn  = 1'b0;
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (st) begin
      m_t0   = c;
      m_h    = (hc == '0) ? 1 : int'(hc);
      m_end  = c + 2 * B + m_h;
      m_btn  = 1'b1;
      m_busy = 1'b1;
      m_tc   = '0;
      sched(c);
    end
  endtask

  task automatic reset_model();
    e = 0; m_btn = 0; m_busy = 0; m_done = 0; m_tc = '0; tq.delete();
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(e, bus.start, bus.hold_cycles);
    e++;
    @(negedge clk);
    chk("cycle_outputs", {bus.btn_out, bus.busy, bus.done, bus.toggle_cnt},
        {m_btn, m_busy, m_done, m_tc});
    chk("seed2_timing", {bus2.busy, bus2.done}, {m_busy, m_done});
    if (bus2.btn_out !== m_btn) diff2++;
  endtask

  task automatic do_reset();
    bus.start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    chk("reset_values", {bus.btn_out, bus.busy, bus.done, bus.toggle_cnt}, 32'd0);
  endtask

  task automatic run_vec(int hold, int exp_done);
    int done_off = -1, busy_n = 0, held_bad = 0, fall_ok = 0;
    int hexp = exp_done - 2 * B;
    bus.start = 1'b1; bus.hold_cycles = HW'(hold);
    step();
    bus.start = 1'b0; bus.hold_cycles = HW'($urandom);  // must not matter now
    if (bus.busy) busy_n++;
    for (int k = 1; k <= 1500 && done_off < 0; k++) begin
      step();
      if (bus.busy) busy_n++;
      if (bus.done) done_off = k;
      if (k >= B && k < B + hexp && bus.btn_out !== 1'b1) held_bad++;
      if (k == B + hexp && bus.btn_out === 1'b0) fall_ok = 1;
    end
    chk("vec_done_offset", done_off, exp_done);
    chk("vec_busy_length", busy_n, exp_done);
    chk("vec_held_stable", held_bad, 0);
    chk("vec_fall_edge", fall_ok, 1);
    chk("vec_toggles_nonzero", {31'd0, bus.toggle_cnt != 8'd0}, 1);
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dn[$];
    int early;
    tbl[0] = '{500, 700};
    tbl[1] = '{0,   201};
    tbl[2] = '{1,   201};
    tbl[3] = '{2,   202};
    tbl[4] = '{37,  237};

    lfsr_tab[0] = SEED;
    for (int i = 1; i < NMAX; i++) lfsr_tab[i] = lfsr_next(lfsr_tab[i-1]);

    diff2 = 0;
    bus.start = 1'b0;
    bus.hold_cycles = '0;
    do_reset();
    repeat (3) step();

    foreach (tbl[i]) run_vec(tbl[i].hold, tbl[i].exp_done);

    // start held high: back-to-back sequences, accepted on each done cycle
    bus.start = 1'b1; bus.hold_cycles = HW'(50);
    early = 0;
    for (int k = 0; k < 800; k++) begin
      step();
      if (bus.done) dn.push_back(e - 1);
      if (!bus.busy && !bus.done) early++;
    end
    bus.start = 1'b0;
    chk("b2b_done_count", {31'd0, dn.size() >= 3}, 1);
    chk("b2b_busy_gaps", early, 0);
    for (int i = 1; i < dn.size(); i++) chk("b2b_period", dn[i] - dn[i-1], 2 * B + 50 + 1);
    for (int k = 0; k < 400 && m_busy; k++) step();

    // async reset in the middle of a press bounce window
    bus.start = 1'b1; bus.hold_cycles = HW'(300);
    step();
    bus.start = 1'b0;
    repeat (37) step();
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {bus.btn_out, bus.busy, bus.done, bus.toggle_cnt}, 32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    chk("reset_release", {bus.btn_out, bus.busy, bus.done, bus.toggle_cnt}, 32'd0);
    repeat (300) step();   // no stray done after the abort
    run_vec(20, 220);      // LFSR restarted from its seed

    // random start/hold traffic
    for (int k = 0; k < 15000; k++) begin
      bus.start = ($urandom_range(0, 19) == 0);
      bus.hold_cycles = HW'($urandom_range(0, 200));
      step();
    end
    bus.start = 1'b0;
    for (int k = 0; k < 500 && m_busy; k++) step();
    chk("drained_idle", {31'd0, m_busy}, 0);
    chk("seed2_pattern_differs", {31'd0, diff2 > 0}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
